acc_bank: RTL
=============

// Module: acc_bank
// PURPOSE
//  Parametrised bank of NACC accumulator registers, WIDTH bits each. Replaces the single accumulator in the datapath.
//  - Each cycle, one entry can be loaded from the A bus, loaded from the ALU result, added to (ALU result) or cleared.
//  - The selected entry is read out through a registered port, with zero/negative/sticky-overflow flags.
//  - A clear-all sweep FSM zeroes the whole bank, one entry per cycle.
// PARAMETERS
//  WIDTH  32  accumulator data width
//  NACC   4   number of accumulator entries (>=2, power of 2)
//  AW     $clog2(NACC)  index width (derived localparam, not overridable)
// PORTS
//  clk       in   1      clock; all state updates on posedge
//  rst       in   1      reset, synchronous, active-high
//  ld_valid  in   1      write request
//  ld_ready  out  1      write accept = (state==IDLE) && !clr_all; combinational
//  ld_idx    in   AW     target entry of write
//  ld_mode   in   2      00 LOAD_A, 01 LOAD_ALU, 10 ADD (entry+alout), 11 CLR
//  alout     in   WIDTH  ALU result
//  a_in      in   WIDTH  A bus operand
//  clr_all   in   1      start clear-all sweep (single-cycle pulse)
//  busy      out  1      sweep in progress
//  rd_idx    in   AW     read select
//  acout     out  WIDTH  registered contents of entry rd_idx
//  acc_zero  out  1      registered: acout==0
//  acc_neg   out  1      registered: acout[WIDTH-1]
//  acc_ovf   out  1      registered: sticky overflow bit of entry rd_idx
// BEHAVIOUR
//  Reset: all entries=0, all ovf=0, acout=0, acc_zero=1, acc_neg=0, acc_ovf=0, state=IDLE, sweep count=0, busy=0.
//  Write fires on ld_valid && ld_ready; the entry updates at that edge.
//  Write effects:
//   - LOAD_A / LOAD_ALU / CLR: write a_in / alout / 0 and clear the entry's ovf.
//   - ADD: signed two's-complement add, entry + alout. ovf is set when both operands share a sign that the result lacks.
//   - ADD: ovf is sticky and never cleared by a later ADD.
//  Read latency: 1 cycle. acout and the flags sample the entry array at the edge.
//  Same-index write and read in one cycle: acout shows the pre-write value; the new value appears the following cycle. No bypass.
//  FSM states:
//   - IDLE: clr_all -> SWEEP with cnt=0. clr_all wins over a same-cycle ld_valid; that write is not accepted.
//   - SWEEP: entry[cnt]=0 and ovf[cnt]=0 each cycle, cnt++. At cnt==NACC-1, clear that entry and -> IDLE.
//   - SWEEP: ld_ready=0, busy=1, and clr_all is ignored.
//  Sweep duration: exactly NACC cycles. ld_ready returns to 1 the cycle after the last clear.
//  Reads stay legal during SWEEP and return the current (partially cleared) contents.
//  rst mid-sweep: all state returns to reset values immediately at that edge.
//  Undefined ld_mode values: none (2-bit fully decoded).
// CONFIGURATION
//  ACC_SATURATE_EN defined:
//   - ADD overflow clamps to 0x7FF..F (positive overflow) or 0x800..0 (negative overflow).
//   - ovf is still set.
//  ACC_SATURATE_EN undefined: ADD wraps modulo 2^WIDTH and ovf is set. Other modes are unaffected either way.
// STRUCTURE
//  acc_pkg (shared package):
//   - mode constants ACC_LOAD_A=2'b00, ACC_LOAD_ALU=2'b01, ACC_ADD=2'b10, ACC_CLR=2'b11.
//   - FSM state enum {ACC_IDLE, ACC_SWEEP}.
//  Sub-module acc_addsat:
//   - combinational WIDTH-parametrised adder: a, b in; sum, ovf out.
//   - the saturation mux sits inside it, under ACC_SATURATE_EN.
//  Top level holds the entry array, ovf vector, sweep FSM/counter and read register.
// TESTING (WIDTH=32, NACC=4; run with and without ACC_SATURATE_EN)
//  1. Reset: rst 1 cycle, then read idx 0..3 -> acout=0, acc_zero=1, acc_ovf=0, ld_ready=1, busy=0.
//  2. LOAD_A a_in=0x10 into idx2, then ADD alout=0x20 into idx2; read idx2 -> 0x30, zero=0, neg=0, ovf=0.
//  3. Overflow: LOAD_ALU 0x7FFFFFFF into idx1, then ADD 1.
//     - Without SAT: 0x80000000, neg=1, ovf=1.
//     - With SAT: 0x7FFFFFFF, ovf=1.
//     - A further LOAD_A 5 clears ovf.
//  4. Sweep: fill idx0..3 with 1..4, pulse clr_all together with ld_valid (idx0, LOAD_A 9).
//     - The write is rejected.
//     - busy=1 and ld_ready=0 for exactly 4 cycles.
//     - All entries read 0 afterwards; idx0 != 9.
//  5. RAW same cycle: idx3=0xA; write LOAD_A 0xB to idx3 with rd_idx=3.
//     - acout=0xA in the next cycle, 0xB in the cycle after.
//  6. rst asserted during the 2nd sweep cycle -> next cycle busy=0, ld_ready=1, all entries 0.

Source files
------------

// File: rtl/acc_pkg.sv
// acc_pkg: shared definitions for the accumulator bank.
//   - ld_mode encodings for entry writes
//   - state type of the clear-all sweep FSM
// No ports. Imported by acc_addsat and acc_bank.
package acc_pkg;

  localparam logic [1:0] ACC_LOAD_A   = 2'b00;
  localparam logic [1:0] ACC_LOAD_ALU = 2'b01;
  localparam logic [1:0] ACC_ADD      = 2'b10;
  localparam logic [1:0] ACC_CLR      = 2'b11;

  typedef enum logic {
    ACC_IDLE  = 1'b0,
    ACC_SWEEP = 1'b1
  } acc_state_t;

endpackage

// File: rtl/acc_addsat.sv
// acc_addsat: combinational signed adder used for ADD updates of an entry.
// Optional feature macro: ACC_SATURATE_EN
//   defined   -> an overflowing sum is clamped to the most positive/negative value
//   undefined -> the sum wraps modulo 2^WIDTH
// In both builds ovf reports signed two's-complement overflow.
// Ports:
//   a    in  WIDTH  current entry value
//   b    in  WIDTH  ALU result to add
//   sum  out WIDTH  result (wrapped or saturated)
//   ovf  out 1      signed overflow of a+b
module acc_addsat
  import acc_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             ovf
);

  logic [WIDTH-1:0] raw;

  // Overflow: operands agree in sign but the wrapped result does not.
  always_comb begin
    raw = a + b;
    ovf = (a[WIDTH-1] == b[WIDTH-1]) && (raw[WIDTH-1] != a[WIDTH-1]);
  end

`ifdef ACC_SATURATE_EN
  // Clamp direction follows the shared operand sign.
  always_comb begin
    sum = raw;
    if (ovf) begin
      sum = a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end
`else
  always_comb begin
    sum = raw;
  end
`endif

endmodule

// File: rtl/acc_bank.sv
// acc_bank: bank of NACC accumulator entries with a registered read port
// and a clear-all sweep that zeroes one entry per cycle.
// Optional feature macro: ACC_SATURATE_EN (saturating ADD, see acc_addsat).
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   ld_valid   write request; fires when ld_ready is also high
//   ld_ready   write accept (idle and no clr_all this cycle), combinational
//   ld_idx     target entry of the write
//   ld_mode    00 LOAD_A, 01 LOAD_ALU, 10 ADD, 11 CLR
//   alout      ALU result
//   a_in       A bus operand
//   clr_all    pulse that starts the clear-all sweep
//   busy       sweep in progress
//   rd_idx     read select
//   acout      registered contents of entry rd_idx
//   acc_zero   registered acout==0
//   acc_neg    registered sign bit of acout
//   acc_ovf    registered sticky overflow bit of entry rd_idx
module acc_bank
  import acc_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NACC  = 4,
  localparam int AW   = $clog2(NACC)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld_valid,
  output logic             ld_ready,
  input  logic [AW-1:0]    ld_idx,
  input  logic [1:0]       ld_mode,
  input  logic [WIDTH-1:0] alout,
  input  logic [WIDTH-1:0] a_in,
  input  logic             clr_all,
  output logic             busy,
  input  logic [AW-1:0]    rd_idx,
  output logic [WIDTH-1:0] acout,
  output logic             acc_zero,
  output logic             acc_neg,
  output logic             acc_ovf
);

  logic [WIDTH-1:0] entry [NACC];
  logic [NACC-1:0]  ovf_vec;

  acc_state_t state, state_nxt;
  logic [AW-1:0] cnt;
  logic          sweep_clr;
  logic          ld_fire;

  logic [WIDTH-1:0] add_sum;
  logic             add_ovf;

  acc_addsat #(.WIDTH(WIDTH)) u_addsat (
    .a   (entry[ld_idx]),
    .b   (alout),
    .sum (add_sum),
    .ovf (add_ovf)
  );

  // State register and sweep counter; the counter is held at 0 while idle
  // so every sweep starts at entry 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ACC_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == ACC_SWEEP) begin
        cnt <= cnt + 1'b1;
      end else begin
        cnt <= '0;
      end
    end
  end

  // Next state: a sweep lasts exactly NACC cycles and cannot be retriggered.
  always_comb begin
    state_nxt = state;
    case (state)
      ACC_IDLE:  if (clr_all) state_nxt = ACC_SWEEP;
      ACC_SWEEP: if (cnt == AW'(NACC - 1)) state_nxt = ACC_IDLE;
      default:   state_nxt = ACC_IDLE;
    endcase
  end

  // Outputs: clr_all takes priority over a same-cycle write request.
  always_comb begin
    busy      = (state == ACC_SWEEP);
    sweep_clr = (state == ACC_SWEEP);
    ld_ready  = (state == ACC_IDLE) && !clr_all;
    ld_fire   = ld_valid && ld_ready;
  end

  // Entry array and overflow vector. ADD keeps ovf sticky; every other
  // write form clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NACC; i++) begin
        entry[i] <= '0;
      end
      ovf_vec <= '0;
    end else if (sweep_clr) begin
      entry[cnt]   <= '0;
      ovf_vec[cnt] <= 1'b0;
    end else if (ld_fire) begin
      case (ld_mode)
        ACC_LOAD_A: begin
          entry[ld_idx]   <= a_in;
          ovf_vec[ld_idx] <= 1'b0;
        end
        ACC_LOAD_ALU: begin
          entry[ld_idx]   <= alout;
          ovf_vec[ld_idx] <= 1'b0;
        end
        ACC_ADD: begin
          entry[ld_idx]   <= add_sum;
          ovf_vec[ld_idx] <= ovf_vec[ld_idx] | add_ovf;
        end
        default: begin
          entry[ld_idx]   <= '0;
          ovf_vec[ld_idx] <= 1'b0;
        end
      endcase
    end
  end

  // Read register samples the array before this edge's write lands,
  // so a same-index write shows up one cycle later (no bypass).
  always_ff @(posedge clk) begin
    if (rst) begin
      acout    <= '0;
      acc_zero <= 1'b1;
      acc_neg  <= 1'b0;
      acc_ovf  <= 1'b0;
    end else begin
      acout    <= entry[rd_idx];
      acc_zero <= (entry[rd_idx] == '0);
      acc_neg  <= entry[rd_idx][WIDTH-1];
      acc_ovf  <= ovf_vec[rd_idx];
    end
  end

endmodule
